param_bus_alu_sequencer: RTL and testbench
==========================================

Name: param_bus_alu_sequencer

Overview:
- Next-generation single-bus datapath with a parametrised register file, Y latch, ALU, double-width Z register and HI/LO registers.
- Adds a control FSM that runs one register-register operation as three bus transfer steps: T_A, T_B, T_WB.
- Provides a start/busy/done handshake and an external register-load port.
- Sits under the future control unit, replacing hand-driven Rin/Rout strobes.

Parameters:
DATA_W, 32, datapath/bus width in bits (power of 2, ≥8)
NUM_REGS, 16, number of general registers (power of 2, ≥2)
REG_AW, $clog2(NUM_REGS), register index width (derived; not overridden)

Ports:
clock  in  1  single system clock, rising edge
clear  in  1  synchronous active-high reset
start  in  1  request an operation; sampled only in IDLE
op  in  3  opcode; latched with start
ra  in  REG_AW  destination register index; latched with start
rb  in  REG_AW  first source index; latched with start
rc  in  REG_AW  second source index; latched with start
ld_en  in  1  external register write strobe
ld_addr  in  REG_AW  external write index
ld_data  in  DATA_W  external write data
busy  out  1  high while the FSM is not in IDLE
done  out  1  one-cycle pulse when the writeback completes
carry  out  1  ADD carry-out / SUB no-borrow of the last ADD/SUB
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register
bus_out  out  DATA_W  current bus value (observability)
dbg_addr  in  REG_AW  debug read index
dbg_data  out  DATA_W  R[dbg_addr], combinational read

Behaviour:
- clear = 1 at a rising edge sets all R[i], Y, Z, hi, lo and carry to 0, FSM to IDLE, and busy and done to 0.
  - This also aborts any in-flight operation: no writeback, no done.
- FSM: IDLE -> T_A -> T_B -> T_WB -> IDLE. One state per cycle, no stalls.
- IDLE:
  - start = 1 latches op, ra, rb and rc, then goes to T_A.
  - bus_out = 0.
- T_A: bus = R[rb]; Y <= bus.
- T_B: bus = R[rc]; Z <= ALU(Y, bus), 2*DATA_W wide.
- T_WB:
  - bus = Z[DATA_W-1:0].
  - Non-MUL ops: R[ra] <= bus.
  - MUL: hi <= Z[2W-1:W] and lo <= Z[W-1:0]; no R write.
  - done is registered and high in the cycle after T_WB, i.e. the first IDLE cycle.
- Latency: start sampled at edge k -> result visible after edge k+3; done = 1 for exactly the cycle between edges k+3 and k+4.
- busy = 1 exactly in T_A, T_B and T_WB.
- Back-to-back: start may be accepted in the same cycle done is high. done still pulses once per operation.
- start while busy: ignored; no queueing.
- ALU (upper Z = 0 unless stated):
  - 000 ADD: Y+bus; carry = carry-out.
  - 001 SUB: Y-bus; carry = 1 iff Y ≥ bus unsigned.
  - 010 AND.
  - 011 OR.
  - 100 SHL: Y << bus[log2(DATA_W)-1:0].
  - 101 SHR: logical, same shift-amount rule as SHL.
  - 110 MUL: unsigned Y*bus, full 2W product.
  - 111 NOT: ~Y; rc is still read but ignored.
  - carry updates only on ADD and SUB and holds otherwise.
- Arithmetic wraps modulo 2^DATA_W in the low word. Shift amounts use only the low log2(DATA_W) bits.
- ld_en:
  - Writes R[ld_addr] <= ld_data only when FSM is IDLE.
  - Ignored (no write) when busy.
  - ld_en and start in the same IDLE cycle: the load takes effect and the operation reads the new value.
- ra may equal rb or rc. Sources are read in T_A/T_B before the T_WB write, so the old value is used.
- hi and lo are written only by MUL. hi/lo have no bus input in this block.
- All registers update only on the rising edge of clock. There are no asynchronous paths except the dbg_data read.

Test Plan:
- Reset/idle: clear for 2 cycles -> busy = 0, done = 0, hi = lo = 0, dbg_data = 0 for every index.
- ADD carry: load R1 = 0xFFFFFFFF and R2 = 0x00000002; start op = 000, ra = 3, rb = 1, rc = 2 -> done on the 4th cycle after start; R3 = 0x00000001; carry = 1; busy high for 3 cycles.
- SUB/SHL chain:
  - R4 = 5, R5 = 7; SUB into R6 -> R6 = 0xFFFFFFFE, carry = 0.
  - Issue start in the done cycle: SHL R7 = R4 << R8 with R8 = 0x21 -> R7 = 0x0000000A (shift by 1).
- MUL: R1 = 0x80000000, R2 = 4, op = 110, ra = 9 -> hi = 0x00000002, lo = 0x00000000; R9 unchanged.
- Hazards:
  - ld_en to R2 while busy -> R2 unchanged.
  - start during busy -> ignored, exactly one done.
  - ld_en + start in the same IDLE cycle -> the op uses the new value.
- Abort: clear asserted during T_B -> no done, destination stays 0, FSM in IDLE the next cycle.

Source files
------------

// File: rtl/param_bus_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : param_bus_alu_sequencer
// Purpose  : Single-bus datapath with a register file, Y latch, ALU,
//            double-width Z register and HI/LO registers. A small FSM runs
//            one register-register operation as three bus transfers
//            (T_A: R[rb]->Y, T_B: R[rc] through the ALU into Z, T_WB: Z->R[ra]
//            or Z->HI/LO for MUL).
// Ports    : clock/clear    - clock and synchronous active-high reset
//            start, op, ra, rb, rc - operation request, latched in IDLE
//            ld_en/ld_addr/ld_data - external register write (IDLE only)
//            busy, done     - handshake (done is a one-cycle pulse)
//            carry, hi, lo  - status and MUL result registers
//            bus_out        - current bus value
//            dbg_addr/dbg_data - combinational register-file read
// Revision : 1.0 - initial release
// ============================================================================
module param_bus_alu_sequencer #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    input  logic [REG_AW-1:0] rc,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy,
    output logic              done,
    output logic              carry,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] bus_out,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int SHW = $clog2(DATA_W);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_SHL = 3'b100;
    localparam logic [2:0] c_OP_SHR = 3'b101;
    localparam logic [2:0] c_OP_MUL = 3'b110;
    localparam logic [2:0] c_OP_NOT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TA   = 2'd1,
        S_TB   = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            op_q;
    logic [REG_AW-1:0]     ra_q, rb_q, rc_q;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     y_q;
    logic [2*DATA_W-1:0]   z_q;
    logic [DATA_W-1:0]     hi_q, lo_q;
    logic                  carry_q;
    logic                  done_q;

    logic                  w_accept;
    logic [DATA_W-1:0]     w_bus;
    logic [DATA_W:0]       w_sum;
    logic [DATA_W:0]       w_diff;
    logic [SHW-1:0]        w_shamt;
    logic [2*DATA_W-1:0]   w_alu_res;
    logic                  w_alu_carry;

    // ------------------------------------------------------------------
    // Control FSM: next state and request acceptance
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        w_accept = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_TA;
                    w_accept = 1'b1;
                end
            end
            S_TA:    state_d = S_TB;
            S_TB:    state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus source select: one driver per transfer step, zero when idle
    // ------------------------------------------------------------------
    always_comb begin
        w_bus = '0;
        case (state_q)
            S_TA:    w_bus = regs_q[rb_q];
            S_TB:    w_bus = regs_q[rc_q];
            S_WB:    w_bus = z_q[DATA_W-1:0];
            default: w_bus = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU: Y is the left operand, the bus the right operand
    // ------------------------------------------------------------------
    assign w_sum   = {1'b0, y_q} + {1'b0, w_bus};
    assign w_diff  = {1'b0, y_q} - {1'b0, w_bus};
    assign w_shamt = w_bus[SHW-1:0];

    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = carry_q;
        case (op_q)
            c_OP_ADD: begin
                w_alu_res   = {{DATA_W{1'b0}}, w_sum[DATA_W-1:0]};
                w_alu_carry = w_sum[DATA_W];
            end
            c_OP_SUB: begin
                // The extended difference goes negative exactly when Y < bus,
                // so the inverted top bit is the no-borrow flag.
                w_alu_res   = {{DATA_W{1'b0}}, w_diff[DATA_W-1:0]};
                w_alu_carry = ~w_diff[DATA_W];
            end
            c_OP_AND: w_alu_res = {{DATA_W{1'b0}}, y_q & w_bus};
            c_OP_OR:  w_alu_res = {{DATA_W{1'b0}}, y_q | w_bus};
            c_OP_SHL: w_alu_res = {{DATA_W{1'b0}}, y_q << w_shamt};
            c_OP_SHR: w_alu_res = {{DATA_W{1'b0}}, y_q >> w_shamt};
            c_OP_MUL: w_alu_res = {{DATA_W{1'b0}}, y_q} * {{DATA_W{1'b0}}, w_bus};
            c_OP_NOT: w_alu_res = {{DATA_W{1'b0}}, ~y_q};
            default:  w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            y_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            // Registered so it lands in the first IDLE cycle after T_WB.
            done_q  <= (state_q == S_WB);

            if (w_accept) begin
                op_q <= op;
                ra_q <= ra;
                rb_q <= rb;
                rc_q <= rc;
            end

            if (state_q == S_TA) begin
                y_q <= w_bus;
            end

            if (state_q == S_TB) begin
                z_q     <= w_alu_res;
                carry_q <= w_alu_carry;
            end

            // External load and writeback live in disjoint states, so the
            // register file never sees two writers in one cycle.
            if (state_q == S_IDLE && ld_en) begin
                regs_q[ld_addr] <= ld_data;
            end

            if (state_q == S_WB) begin
                if (op_q == c_OP_MUL) begin
                    hi_q <= z_q[2*DATA_W-1:DATA_W];
                    lo_q <= z_q[DATA_W-1:0];
                end else begin
                    regs_q[ra_q] <= w_bus;
                end
            end
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign carry    = carry_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign bus_out  = w_bus;
    assign dbg_data = regs_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_param_bus_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_bus_alu_sequencer
// Purpose  : Directed self-checking bench for param_bus_alu_sequencer with
//            hand-computed expected values (DATA_W = 32, NUM_REGS = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_bus_alu_sequencer;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;

    logic              clock;
    logic              clear;
    logic              start;
    logic [2:0]        op;
    logic [REG_AW-1:0] ra, rb, rc;
    logic              ld_en;
    logic [REG_AW-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              busy, done, carry;
    logic [DATA_W-1:0] hi, lo, bus_out;
    logic [REG_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    int n_checks = 0;
    int n_pass   = 0;

    param_bus_alu_sequencer #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .ra       (ra),
        .rb       (rb),
        .rc       (rc),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .busy     (busy),
        .done     (done),
        .carry    (carry),
        .hi       (hi),
        .lo       (lo),
        .bus_out  (bus_out),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd_check(input string tag, input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] exp);
        dbg_addr = a;
        #1;
        check(tag, {32'd0, dbg_data}, {32'd0, exp});
    endtask

    task automatic load(input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    // Issue an operation now; returns in the done cycle (start may be
    // re-issued immediately for back-to-back operation).
    task automatic run_op(input logic [2:0] o, input logic [REG_AW-1:0] d,
                          input logic [REG_AW-1:0] s1, input logic [REG_AW-1:0] s2);
        start = 1'b1;
        op    = o;
        ra    = d;
        rb    = s1;
        rc    = s2;
        tick();
        start = 1'b0;
        ld_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("busy_in_op", {63'd0, busy}, 64'd1);
            check("done_early", {63'd0, done}, 64'd0);
            tick();
        end
        check("busy_after_op", {63'd0, busy}, 64'd0);
        check("done_pulse", {63'd0, done}, 64'd1);
    endtask

    initial begin
        clear    = 1'b1;
        start    = 1'b0;
        op       = '0;
        ra       = '0;
        rb       = '0;
        rc       = '0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        dbg_addr = '0;

        // Reset / idle
        tick();
        tick();
        clear = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_carry", {63'd0, carry}, 64'd0);
        check("rst_bus", {32'd0, bus_out}, 64'd0);
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_check("rst_reg", REG_AW'(i), 32'h0);
        end
        tick();

        // ADD with carry-out
        load(4'd1, 32'hFFFF_FFFF);
        load(4'd2, 32'h0000_0002);
        run_op(3'b000, 4'd3, 4'd1, 4'd2);
        tick();
        check("add_done_once", {63'd0, done}, 64'd0);
        check("add_carry", {63'd0, carry}, 64'd1);
        rd_check("add_r3", 4'd3, 32'h0000_0001);
        tick();

        // OR leaves carry untouched
        run_op(3'b011, 4'd10, 4'd1, 4'd2);
        tick();
        rd_check("or_r10", 4'd10, 32'hFFFF_FFFF);
        check("or_carry_hold", {63'd0, carry}, 64'd1);
        tick();

        // SUB then back-to-back SHL issued in the done cycle
        load(4'd4, 32'd5);
        load(4'd5, 32'd7);
        load(4'd8, 32'h21);
        run_op(3'b001, 4'd6, 4'd4, 4'd5);
        run_op(3'b100, 4'd7, 4'd4, 4'd8);
        tick();
        check("shl_done_once", {63'd0, done}, 64'd0);
        rd_check("sub_r6", 4'd6, 32'hFFFF_FFFE);
        check("sub_carry", {63'd0, carry}, 64'd0);
        rd_check("shl_r7", 4'd7, 32'h0000_000A);
        tick();

        // SHR with shift-amount masking: 0x80000000 >> (0x3F & 31) = 1
        load(4'd12, 32'h8000_0000);
        load(4'd13, 32'h3F);
        run_op(3'b101, 4'd11, 4'd12, 4'd13);
        tick();
        rd_check("shr_r11", 4'd11, 32'h0000_0001);
        tick();

        // NOT (rc ignored), ra == rb: old source value used
        run_op(3'b111, 4'd5, 4'd5, 4'd1);
        tick();
        rd_check("not_r5", 4'd5, 32'hFFFF_FFF8);
        tick();

        // MUL into HI/LO, destination untouched
        load(4'd1, 32'h8000_0000);
        load(4'd2, 32'h0000_0004);
        run_op(3'b110, 4'd9, 4'd1, 4'd2);
        tick();
        check("mul_hi", {32'd0, hi}, 64'h2);
        check("mul_lo", {32'd0, lo}, 64'h0);
        check("mul_carry_hold", {63'd0, carry}, 64'd0);
        rd_check("mul_r9", 4'd9, 32'h0);
        tick();

        // Hazards: load and start while busy are both ignored
        start = 1'b1;
        op    = 3'b000;
        ra    = 4'd14;
        rb    = 4'd1;
        rc    = 4'd2;
        tick();
        ld_en   = 1'b1;
        ld_addr = 4'd2;
        ld_data = 32'h0000_1234;
        ra      = 4'd15;
        check("hz_busy_ta", {63'd0, busy}, 64'd1);
        tick();
        check("hz_done_tb", {63'd0, done}, 64'd0);
        tick();
        check("hz_done_wb", {63'd0, done}, 64'd0);
        tick();
        start = 1'b0;
        ld_en = 1'b0;
        check("hz_done", {63'd0, done}, 64'd1);
        check("hz_idle", {63'd0, busy}, 64'd0);
        tick();
        check("hz_done_once", {63'd0, done}, 64'd0);
        check("hz_no_requeue", {63'd0, busy}, 64'd0);
        rd_check("hz_r2_kept", 4'd2, 32'h0000_0004);
        rd_check("hz_r14", 4'd14, 32'h8000_0004);
        rd_check("hz_r15_clean", 4'd15, 32'h0);
        tick();

        // Load and start in the same IDLE cycle: op sees the new value
        ld_en   = 1'b1;
        ld_addr = 4'd13;
        ld_data = 32'h0000_0010;
        run_op(3'b000, 4'd0, 4'd13, 4'd2);
        tick();
        rd_check("ldst_r0", 4'd0, 32'h0000_0014);
        tick();

        // Abort: clear during T_B
        start = 1'b1;
        op    = 3'b000;
        ra    = 4'd15;
        rb    = 4'd1;
        rc    = 4'd2;
        tick();
        start = 1'b0;
        tick();
        check("abort_in_tb", {63'd0, busy}, 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_idle", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        tick();
        check("abort_no_done", {63'd0, done}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        rd_check("abort_r15", 4'd15, 32'h0);
        rd_check("abort_r1", 4'd1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
